// File: rtl/pmod_jstk_reader_pkg.sv
// Shared types and constants for the PmodJSTK SPI reader: FSM encoding,
// command prefix, transaction length and the joystick centre value.
package pmod_jstk_reader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_GAP   = 3'd3,
      ST_DONE  = 3'd4
   } jstk_state_t;

   localparam logic [5:0] JSTK_CMD_LED = 6'b100000;
   localparam int         NUM_BYTES    = 5;
   localparam logic [9:0] JSTK_CENTER  = 10'h200;

   // First byte of every transaction: LED command prefix plus the two LED bits.
   function automatic logic [7:0] jstk_cmd_byte(input logic led2, input logic led1);
      return {JSTK_CMD_LED, led2, led1};
   endfunction

endpackage

// File: rtl/pmod_jstk_reader_if.sv
// Four-wire SPI bus between the joystick reader (master) and the PmodJSTK (slave).
interface pmod_jstk_reader_if;
   logic cs;
   logic sck;
   logic mosi;
   logic miso;

   modport master (output cs, output sck, output mosi, input miso);
   modport slave  (input cs, input sck, input mosi, output miso);
endinterface

// File: rtl/pmod_jstk_reader_spi_byte_shifter.sv
// Mode-0, MSB-first, 8-bit SPI shift engine. sck rises on the start edge, so the
// caller owns the setup time before each byte; done fires on the 8th falling edge.
module spi_byte_shifter #(
   parameter int CLK_DIV = 50
) (
   input  logic       clk50M,
   input  logic       reset_n,
   input  logic       start,
   input  logic [7:0] tx_byte,
   input  logic       miso,
   output logic [7:0] rx_byte,
   output logic       done,
   output logic       sck,
   output logic       mosi
);
   localparam int DIV_W = $clog2(CLK_DIV + 1);

   logic             busy_reg;
   logic             sck_reg;
   logic             mosi_reg;
   logic [DIV_W-1:0] div_cnt_reg;
   logic [2:0]       bit_cnt_reg;
   logic [7:0]       tx_reg;
   logic [7:0]       rx_reg;
   logic             half_end;

   assign half_end = busy_reg && (div_cnt_reg == DIV_W'(CLK_DIV - 1));
   // Combinational so the sequencer leaves SHIFT on the very edge sck falls.
   assign done     = half_end && sck_reg && (bit_cnt_reg == 3'd7);
   assign rx_byte  = rx_reg;
   assign sck      = sck_reg;
   assign mosi     = mosi_reg;

   always_ff @(posedge clk50M or negedge reset_n) begin
      if (!reset_n) begin
         busy_reg    <= 1'b0;
         sck_reg     <= 1'b0;
         mosi_reg    <= 1'b0;
         div_cnt_reg <= '0;
         bit_cnt_reg <= '0;
         tx_reg      <= '0;
         rx_reg      <= '0;
      end else if (start) begin
         busy_reg    <= 1'b1;
         sck_reg     <= 1'b1;
         div_cnt_reg <= '0;
         bit_cnt_reg <= '0;
         mosi_reg    <= tx_byte[7];
         tx_reg      <= {tx_byte[6:0], 1'b0};
         rx_reg      <= {rx_reg[6:0], miso};
      end else if (half_end) begin
         div_cnt_reg <= '0;
         if (sck_reg) begin
            sck_reg <= 1'b0;
            if (bit_cnt_reg == 3'd7) begin
               busy_reg <= 1'b0;
            end else begin
               bit_cnt_reg <= bit_cnt_reg + 3'd1;
               mosi_reg    <= tx_reg[7];
               tx_reg      <= {tx_reg[6:0], 1'b0};
            end
         end else begin
            sck_reg <= 1'b1;
            rx_reg  <= {rx_reg[6:0], miso};
         end
      end else if (busy_reg) begin
         div_cnt_reg <= div_cnt_reg + DIV_W'(1);
      end
   end

endmodule

// File: rtl/pmod_jstk_reader.sv
// Periodically polls a PmodJSTK over SPI: one 5-byte transaction per poll period,
// publishing x/y/btn atomically with a one-cycle sample_valid when it completes.
module pmod_jstk_reader
   import pmod_jstk_reader_pkg::*;
#(
   parameter int CLK_DIV     = 50,
   parameter int CS_SETUP    = 750,
   parameter int BYTE_GAP    = 500,
   parameter int POLL_PERIOD = 50000
) (
   input  logic               clk50M,
   input  logic               reset_n,
   input  logic               led1,
   input  logic               led2,
   output logic [9:0]         x,
   output logic [9:0]         y,
   output logic [2:0]         btn,
   output logic               sample_valid,
   pmod_jstk_reader_if.master spi
);
   localparam int POLL_W   = $clog2(POLL_PERIOD + 1);
   localparam int WAIT_MAX = (CS_SETUP > BYTE_GAP) ? CS_SETUP : BYTE_GAP;
   localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

   jstk_state_t       state_reg;
   logic [POLL_W-1:0] poll_cnt_reg;
   logic [WAIT_W-1:0] wait_cnt_reg;
   logic [2:0]        byte_idx_reg;
   logic [7:0]        cmd_reg;
   logic              cs_reg;
   logic              mosi_reg;
   logic [9:0]        x_stage_reg;
   logic [9:0]        y_stage_reg;
   logic [2:0]        btn_stage_reg;
   logic [9:0]        x_reg;
   logic [9:0]        y_reg;
   logic [2:0]        btn_reg;
   logic              valid_reg;

   logic              poll_wrap;
   logic              setup_end;
   logic              gap_end;
   logic              sh_start;
   logic [7:0]        sh_tx_byte;
   logic [7:0]        sh_rx_byte;
   logic              sh_done;
   logic              sh_sck;
   logic              sh_mosi;

   assign poll_wrap  = (poll_cnt_reg == POLL_W'(POLL_PERIOD - 1));
   assign setup_end  = (state_reg == ST_SETUP) && (wait_cnt_reg == WAIT_W'(CS_SETUP - 1));
   assign gap_end    = (state_reg == ST_GAP) && (wait_cnt_reg == WAIT_W'(BYTE_GAP - 1));
   assign sh_start   = setup_end || gap_end;
   // GAP always precedes a data byte, which is all zeros; only SETUP leads into the command.
   assign sh_tx_byte = (state_reg == ST_SETUP) ? cmd_reg : 8'h00;

   spi_byte_shifter #(
      .CLK_DIV (CLK_DIV)
   ) u_shifter (
      .clk50M  (clk50M),
      .reset_n (reset_n),
      .start   (sh_start),
      .tx_byte (sh_tx_byte),
      .miso    (spi.miso),
      .rx_byte (sh_rx_byte),
      .done    (sh_done),
      .sck     (sh_sck),
      .mosi    (sh_mosi)
   );

   // Free-running so the poll cadence does not depend on transaction length.
   always_ff @(posedge clk50M or negedge reset_n) begin
      if (!reset_n) begin
         poll_cnt_reg <= '0;
      end else if (poll_wrap) begin
         poll_cnt_reg <= '0;
      end else begin
         poll_cnt_reg <= poll_cnt_reg + POLL_W'(1);
      end
   end

   always_ff @(posedge clk50M or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= ST_IDLE;
         wait_cnt_reg  <= '0;
         byte_idx_reg  <= '0;
         cmd_reg       <= '0;
         cs_reg        <= 1'b1;
         mosi_reg      <= 1'b0;
         x_stage_reg   <= '0;
         y_stage_reg   <= '0;
         btn_stage_reg <= '0;
         x_reg         <= JSTK_CENTER;
         y_reg         <= JSTK_CENTER;
         btn_reg       <= '0;
         valid_reg     <= 1'b0;
      end else begin
         valid_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (poll_wrap) begin
                  state_reg    <= ST_SETUP;
                  cs_reg       <= 1'b0;
                  cmd_reg      <= jstk_cmd_byte(led2, led1);
                  mosi_reg     <= JSTK_CMD_LED[5];
                  wait_cnt_reg <= '0;
                  byte_idx_reg <= '0;
               end
            end
            ST_SETUP: begin
               if (setup_end) begin
                  state_reg <= ST_SHIFT;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
               end
            end
            ST_SHIFT: begin
               if (sh_done) begin
                  wait_cnt_reg <= '0;
                  case (byte_idx_reg)
                     3'd0:    x_stage_reg[7:0] <= sh_rx_byte;
                     3'd1:    x_stage_reg[9:8] <= sh_rx_byte[1:0];
                     3'd2:    y_stage_reg[7:0] <= sh_rx_byte;
                     3'd3:    y_stage_reg[9:8] <= sh_rx_byte[1:0];
                     default: btn_stage_reg    <= sh_rx_byte[2:0];
                  endcase
                  if (byte_idx_reg == 3'(NUM_BYTES - 1)) begin
                     state_reg <= ST_DONE;
                  end else begin
                     state_reg <= ST_GAP;
                     mosi_reg  <= 1'b0;
                  end
               end
            end
            ST_GAP: begin
               if (gap_end) begin
                  state_reg    <= ST_SHIFT;
                  byte_idx_reg <= byte_idx_reg + 3'd1;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
               end
            end
            ST_DONE: begin
               state_reg    <= ST_IDLE;
               cs_reg       <= 1'b1;
               mosi_reg     <= 1'b0;
               byte_idx_reg <= '0;
               x_reg        <= x_stage_reg;
               y_reg        <= y_stage_reg;
               btn_reg      <= btn_stage_reg;
               valid_reg    <= 1'b1;
            end
            default: begin
               state_reg <= ST_IDLE;
               cs_reg    <= 1'b1;
            end
         endcase
      end
   end

   assign spi.cs       = cs_reg;
   assign spi.sck      = sh_sck;
   assign spi.mosi     = (state_reg == ST_SHIFT) ? sh_mosi : mosi_reg;
   assign x            = x_reg;
   assign y            = y_reg;
   assign btn          = btn_reg;
   assign sample_valid = valid_reg;

endmodule
